hilo_div_ctrl: RTL and testbench

- Execute-stage HI/LO unit controller.
- Accepts DIV/DIVU/MTHI/MTLO operations from the EX stage and handles signed operands by magnitude conversion.
- Launches the 32-cycle iterative unsigned divider core over a start/busy handshake, sign-fixes the core's quotient/remainder, and commits them to the HI/LO architectural registers.
- Holds the pipeline stalled while a division is in flight.

---
 rtl/hilo_div_ctrl_pkg.sv | 34 +++
 rtl/hilo_div_ctrl_div_sign_fix.sv | 33 +++
 rtl/hilo_div_ctrl.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_hilo_div_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hilo_div_ctrl_pkg
//   Shared types and constants for the execute-stage HI/LO division controller.
//   - op_sel_t  : encoding of the EX-stage HI/LO operation selector
//   - state_t   : controller FSM states
//   - DIV_ITERS : iteration count of the external unsigned divider core
//   - DIV_ZERO_Q: architectural quotient produced by a divide by zero
// -----------------------------------------------------------------------------
package hilo_div_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_DIVU = 2'd0,
      OP_DIV  = 2'd1,
      OP_MTHI = 2'd2,
      OP_MTLO = 2'd3
   } op_sel_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_ARM   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_FIX   = 3'd4
   } state_t;

   localparam int          DIV_ITERS  = 32;
   localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

   // True for the two operations that go through the divider core.
   function automatic logic is_div_op(input op_sel_t op);
      return (op == OP_DIVU) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/hilo_div_ctrl_div_sign_fix.sv
// -----------------------------------------------------------------------------
// div_sign_fix
//   Combinational conditional two's-complement negate. Used both to turn
//   signed operands into magnitudes for the unsigned divider core and to
//   restore the sign of the core's quotient/remainder.
//
// Ports:
//   neg    in  1      negate when high
//   value  in  WIDTH  input word
//   result out WIDTH  neg ? -value : value
// -----------------------------------------------------------------------------
module div_sign_fix
   import hilo_div_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             neg,
   input  logic [WIDTH-1:0] value,
   output logic [WIDTH-1:0] result
);

   // Negating the most negative value yields itself, which is exactly the
   // unsigned magnitude the core needs (0x80000000 -> 0x80000000).
   function automatic logic [WIDTH-1:0] cond_negate(input logic             n,
                                                    input logic [WIDTH-1:0] v);
      logic signed [WIDTH-1:0] v_s;
      v_s = signed'(v);
      return n ? unsigned'(-v_s) : v;
   endfunction

   assign result = cond_negate(neg, value);

endmodule

// File: rtl/hilo_div_ctrl.sv
// -----------------------------------------------------------------------------
// hilo_div_ctrl
//   Execute-stage HI/LO unit controller. Accepts DIVU/DIV/MTHI/MTLO from EX,
//   converts signed operands to magnitudes, launches an external 32-cycle
//   iterative unsigned divider core over a start/busy handshake, sign-corrects
//   its quotient/remainder and commits them to HI/LO. The pipeline is stalled
//   while a division is in flight.
//
// Optional feature (compile-time macro DIV_ZERO_TRAP_EN):
//   defined   : adds output div_zero_exc; a divide by zero pulses it for one
//               cycle, leaves HI/LO unchanged, does not stall, no done pulse.
//   undefined : divide by zero writes HI=op_a, LO=all ones, done pulses the
//               following cycle.
//
// Ports:
//   clock          in   system clock
//   reset          in   synchronous active-high reset
//   op_valid       in   EX-stage operation valid
//   op_sel         in   0=DIVU 1=DIV 2=MTHI 3=MTLO
//   op_a / op_b    in   dividend (or MTHI/MTLO source) / divisor
//   flush          in   exception flush, aborts an in-flight division
//   stall          out  pipeline stall request
//   done           out  one-cycle pulse when a division commits
//   err            out  one-cycle pulse on watchdog expiry
//   hi / lo        out  architectural HI/LO registers
//   core_start     out  divider core start
//   core_dividend  out  dividend magnitude to the core
//   core_divisor   out  divisor magnitude to the core
//   core_busy      in   divider core busy
//   core_q/core_r  in   core quotient / remainder
//   div_zero_exc   out  divide-by-zero trap pulse (DIV_ZERO_TRAP_EN only)
// -----------------------------------------------------------------------------
module hilo_div_ctrl
   import hilo_div_ctrl_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MAX_WAIT = 40
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             op_valid,
   input  logic [1:0]       op_sel,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             stall,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             core_start,
   output logic [WIDTH-1:0] core_dividend,
   output logic [WIDTH-1:0] core_divisor,
   input  logic             core_busy,
   input  logic [WIDTH-1:0] core_q,
   input  logic [WIDTH-1:0] core_r
`ifdef DIV_ZERO_TRAP_EN
   ,
   output logic             div_zero_exc
`endif
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);
   localparam int MSB   = WIDTH - 1;

   state_t           state;
   state_t           state_nxt;
   op_sel_t          op;

   logic             accept;
   logic             div_req;
   logic             signed_op;
   logic             b_zero;
   logic             launch;
   logic             div_zero;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] fixed_q;
   logic [WIDTH-1:0] fixed_r;

   logic [WIDTH-1:0] dividend_r;
   logic [WIDTH-1:0] divisor_r;
   logic             neg_q;
   logic             neg_r;

   logic [CNT_W-1:0] wait_cnt;
   logic             wd_hit;
   logic             commit;

`ifndef DIV_ZERO_TRAP_EN
   logic             dz_done;
`endif

   // --- Request decode ------------------------------------------------------
   // A flush in IDLE kills the presented op outright, so it is never accepted.
   assign op        = op_sel_t'(op_sel);
   assign accept    = (state == ST_IDLE) && op_valid && !flush;
   assign div_req   = accept && is_div_op(op);
   assign signed_op = (op == OP_DIV);
   assign b_zero    = (op_b == '0);
   assign launch    = div_req && !b_zero;
   assign div_zero  = div_req && b_zero;

   assign a_neg = signed_op && op_a[MSB];
   assign b_neg = signed_op && op_b[MSB];

   div_sign_fix #(.WIDTH(WIDTH)) u_mag_a (
      .neg    (a_neg),
      .value  (op_a),
      .result (mag_a)
   );

   div_sign_fix #(.WIDTH(WIDTH)) u_mag_b (
      .neg    (b_neg),
      .value  (op_b),
      .result (mag_b)
   );

   // Result correction: quotient is negative when operand signs differ,
   // remainder takes the sign of the dividend (truncating division).
   div_sign_fix #(.WIDTH(WIDTH)) u_fix_q (
      .neg    (neg_q),
      .value  (core_q),
      .result (fixed_q)
   );

   div_sign_fix #(.WIDTH(WIDTH)) u_fix_r (
      .neg    (neg_r),
      .value  (core_r),
      .result (fixed_r)
   );

   // --- Operand latch (data only, no reset) ---------------------------------
   always_ff @(posedge clock) begin
      if (launch) begin
         dividend_r <= mag_a;
         divisor_r  <= mag_b;
         neg_q      <= a_neg ^ b_neg;
         neg_r      <= a_neg;
      end
   end

   assign core_dividend = dividend_r;
   assign core_divisor  = divisor_r;

   // --- Watchdog ------------------------------------------------------------
   // Counts cycles spent waiting on the core; cleared whenever not waiting.
   // The >= compare keeps firing even if busy rose on the very cycle the limit
   // was reached in ARM.
   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if ((state == ST_ARM) || (state == ST_WAIT)) begin
         wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
         wait_cnt <= '0;
      end
   end

   assign wd_hit = ((state == ST_ARM) || (state == ST_WAIT)) &&
                   (wait_cnt >= CNT_W'(MAX_WAIT - 1));

   // --- FSM state register --------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // --- FSM next state ------------------------------------------------------
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (launch) begin
               state_nxt = ST_START;
            end
         end
         ST_START: begin
            state_nxt = ST_ARM;
         end
         ST_ARM: begin
            if (core_busy) begin
               state_nxt = ST_WAIT;
            end else if (wd_hit) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!core_busy) begin
               state_nxt = ST_FIX;
            end else if (wd_hit) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_FIX: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      // Flush abandons whatever the core is doing; the next start restarts it.
      if (flush && (state != ST_IDLE)) begin
         state_nxt = ST_IDLE;
      end
   end

   // --- FSM outputs ---------------------------------------------------------
   always_comb begin
      stall      = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      core_start = 1'b0;
      commit     = 1'b0;
      unique case (state)
         ST_IDLE: begin
`ifdef DIV_ZERO_TRAP_EN
            stall = launch;
`else
            // Divide by zero resolves in the accept cycle but still stalls it.
            stall = div_req;
            done  = dz_done;
`endif
         end
         ST_START: begin
            stall      = 1'b1;
            core_start = !flush;
         end
         ST_ARM: begin
            stall = 1'b1;
            err   = wd_hit && !core_busy && !flush;
         end
         ST_WAIT: begin
            stall = 1'b1;
            err   = wd_hit && core_busy && !flush;
         end
         ST_FIX: begin
            stall  = 1'b1;
            commit = !flush;
            done   = !flush;
         end
         default: begin
            stall = 1'b0;
         end
      endcase
   end

   // --- HI/LO architectural registers ---------------------------------------
   // commit only happens in FIX and accept only in IDLE, so the branches below
   // never compete in the same cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         hi <= '0;
         lo <= '0;
      end else if (commit) begin
         hi <= fixed_r;
         lo <= fixed_q;
`ifndef DIV_ZERO_TRAP_EN
      end else if (div_zero) begin
         hi <= op_a;
         lo <= WIDTH'(DIV_ZERO_Q);
`endif
      end else if (accept && (op == OP_MTHI)) begin
         hi <= op_a;
      end else if (accept && (op == OP_MTLO)) begin
         lo <= op_a;
      end
   end

`ifdef DIV_ZERO_TRAP_EN
   assign div_zero_exc = div_zero;
`else
   // done for a divide by zero arrives the cycle after the HI/LO write.
   always_ff @(posedge clock) begin
      if (reset) begin
         dz_done <= 1'b0;
      end else begin
         dz_done <= div_zero;
      end
   end
`endif

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hilo_div_ctrl
//   Directed bench for hilo_div_ctrl. A behavioural divider core answers the
//   start/busy handshake. Expected outputs are kept as per-cycle timelines
//   filled from the operation-level rules (latency, stall window, result
//   arithmetic), compared on every falling edge, plus literal HI/LO values.
// -----------------------------------------------------------------------------
module tb_hilo_div_ctrl;
   import hilo_div_ctrl_pkg::*;

   localparam int WIDTH    = 32;
   localparam int MAX_WAIT = 40;
   localparam int N        = 1024;
   localparam int LAT      = 3 + DIV_ITERS;  // accept + START + ARM + WAIT

   logic        clock = 1'b0;
   logic        reset;
   logic        op_valid;
   logic [1:0]  op_sel;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic        flush;
   logic        stall;
   logic        done;
   logic        err;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        core_start;
   logic [31:0] core_dividend;
   logic [31:0] core_divisor;
   logic        core_busy;
   logic [31:0] core_q = '0;
   logic [31:0] core_r = '0;
`ifdef DIV_ZERO_TRAP_EN
   logic        div_zero_exc;
`endif

   int          cyc      = 0;
   int          checks   = 0;
   int          errors   = 0;
   bit          chk_en   = 1'b0;
   bit          hold_busy = 1'b0;
   int          busy_cnt = 0;

   bit          e_stall [N];
   bit          e_done  [N];
   bit          e_err   [N];
   bit          e_start [N];
   bit          e_dze   [N];
   logic [31:0] e_hi    [N];
   logic [31:0] e_lo    [N];
   logic [31:0] e_dvd   [N];
   logic [31:0] e_dvs   [N];

   hilo_div_ctrl #(.WIDTH(WIDTH), .MAX_WAIT(MAX_WAIT)) dut (
      .clock         (clock),
      .reset         (reset),
      .op_valid      (op_valid),
      .op_sel        (op_sel),
      .op_a          (op_a),
      .op_b          (op_b),
      .flush         (flush),
      .stall         (stall),
      .done          (done),
      .err           (err),
      .hi            (hi),
      .lo            (lo),
      .core_start    (core_start),
      .core_dividend (core_dividend),
      .core_divisor  (core_divisor),
      .core_busy     (core_busy),
      .core_q        (core_q),
      .core_r        (core_r)
`ifdef DIV_ZERO_TRAP_EN
      ,
      .div_zero_exc  (div_zero_exc)
`endif
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Behavioural divider core: start always (re)launches, busy for DIV_ITERS.
   always @(posedge clock) begin
      if (core_start) begin
         busy_cnt <= DIV_ITERS;
         core_q   <= (core_divisor != 0) ? core_dividend / core_divisor : '1;
         core_r   <= (core_divisor != 0) ? core_dividend % core_divisor : core_dividend;
      end else if (busy_cnt != 0) begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   assign core_busy = hold_busy || (busy_cnt != 0);

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got 0x%08h expected 0x%08h", nm, cyc, act, exp);
      end
   endtask

   // --- Model ---------------------------------------------------------------
   task automatic set_hi(input int from, input logic [31:0] v);
      for (int k = from; k < N; k++) e_hi[k] = v;
   endtask

   task automatic set_lo(input int from, input logic [31:0] v);
      for (int k = from; k < N; k++) e_lo[k] = v;
   endtask

   function automatic logic [31:0] mag(input bit sgn, input logic [31:0] v);
      return (sgn && v[31]) ? -v : v;
   endfunction

   task automatic exp_launch(input int c, input int last, input bit sgn,
                             input logic [31:0] a, input logic [31:0] b);
      for (int k = c; k <= last; k++) e_stall[k] = 1'b1;
      e_start[c+1] = 1'b1;
      e_dvd[c+1]   = mag(sgn, a);
      e_dvs[c+1]   = mag(sgn, b);
   endtask

   // Complete division accepted in cycle c.
   task automatic model_div(input int c, input bit sgn, input logic [31:0] a, input logic [31:0] b);
      longint q;
      longint r;
      if (b == 0) begin
`ifdef DIV_ZERO_TRAP_EN
         e_dze[c] = 1'b1;
`else
         e_stall[c]  = 1'b1;
         e_done[c+1] = 1'b1;
         set_hi(c + 1, a);
         set_lo(c + 1, 32'hFFFF_FFFF);
`endif
      end else begin
         if (sgn) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
         end else begin
            q = longint'(a) / longint'(b);
            r = longint'(a) % longint'(b);
         end
         exp_launch(c, c + LAT, sgn, a, b);
         e_done[c+LAT] = 1'b1;
         set_hi(c + LAT + 1, r[31:0]);
         set_lo(c + LAT + 1, q[31:0]);
      end
   endtask

   // --- Compare process -----------------------------------------------------
   always @(negedge clock) begin
      if (chk_en && (cyc < N)) begin
         cmp("stall", {31'd0, stall}, {31'd0, e_stall[cyc]});
         cmp("done", {31'd0, done}, {31'd0, e_done[cyc]});
         cmp("err", {31'd0, err}, {31'd0, e_err[cyc]});
         cmp("core_start", {31'd0, core_start}, {31'd0, e_start[cyc]});
         cmp("hi", hi, e_hi[cyc]);
         cmp("lo", lo, e_lo[cyc]);
`ifdef DIV_ZERO_TRAP_EN
         cmp("div_zero_exc", {31'd0, div_zero_exc}, {31'd0, e_dze[cyc]});
`endif
         if (e_start[cyc]) begin
            cmp("core_dividend", core_dividend, e_dvd[cyc]);
            cmp("core_divisor", core_divisor, e_dvs[cyc]);
         end
      end
   end

   // --- Stimulus ------------------------------------------------------------
   task automatic drive(input bit v, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] b, input bit fl);
      @(posedge clock);
      #1;
      op_valid = v;
      op_sel   = s;
      op_a     = a;
      op_b     = b;
      flush    = fl;
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
   endtask

   initial begin
      int c;
      for (int k = 0; k < N; k++) begin
         e_hi[k]  = '0;
         e_lo[k]  = '0;
         e_dvd[k] = '0;
         e_dvs[k] = '0;
      end
      reset    = 1'b1;
      op_valid = 1'b0;
      op_sel   = 2'd0;
      op_a     = '0;
      op_b     = '0;
      flush    = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      cmp("reset_hi", hi, 32'd0);
      cmp("reset_lo", lo, 32'd0);
      cmp("reset_stall", {31'd0, stall}, 32'd0);
      cmp("reset_done", {31'd0, done}, 32'd0);
      cmp("reset_err", {31'd0, err}, 32'd0);
      cmp("reset_core_start", {31'd0, core_start}, 32'd0);
      chk_en = 1'b1;

      // 1: DIVU 100/7, with an MTHI presented mid-division that must be ignored
      drive(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
      c = cyc;
      model_div(c, 1'b0, 32'd100, 32'd7);
      wait_until(c + 20);
      drive(1'b1, OP_MTHI, 32'h1234, 32'd0, 1'b0);
      wait_until(c + LAT + 2);
      cmp("t1_lo", lo, 32'd14);
      cmp("t1_hi", hi, 32'd2);

      // 2: signed division sign handling
      drive(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      c = cyc;
      model_div(c, 1'b1, 32'hFFFF_FFF9, 32'd2);
      wait_until(c + LAT + 2);
      cmp("t2a_lo", lo, 32'hFFFF_FFFD);
      cmp("t2a_hi", hi, 32'hFFFF_FFFF);

      drive(1'b1, OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
      c = cyc;
      model_div(c, 1'b1, 32'd7, 32'hFFFF_FFFE);
      wait_until(c + LAT + 2);
      cmp("t2b_lo", lo, 32'hFFFF_FFFD);
      cmp("t2b_hi", hi, 32'd1);

      // 3: most-negative / -1 overflow, no error
      drive(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      c = cyc;
      model_div(c, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_until(c + LAT + 2);
      cmp("t3_lo", lo, 32'h8000_0000);
      cmp("t3_hi", hi, 32'd0);

      // 4: divide by zero
      drive(1'b1, OP_DIVU, 32'd5, 32'd0, 1'b0);
      c = cyc;
      model_div(c, 1'b0, 32'd5, 32'd0);
      wait_until(c + 2);
`ifdef DIV_ZERO_TRAP_EN
      cmp("t4_hi", hi, 32'd0);
      cmp("t4_lo", lo, 32'h8000_0000);
`else
      cmp("t4_hi", hi, 32'd5);
      cmp("t4_lo", lo, 32'hFFFF_FFFF);
`endif

      // 5: flush on the 10th WAIT cycle, then relaunch while core still busy
      drive(1'b1, OP_DIVU, 32'd100, 32'd7, 1'b0);
      c = cyc;
      exp_launch(c, c + 12, 1'b0, 32'd100, 32'd7);
      wait_until(c + 11);
      drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b1);
      drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
`ifdef DIV_ZERO_TRAP_EN
      cmp("t5_flush_hi", hi, 32'd0);
      cmp("t5_flush_lo", lo, 32'h8000_0000);
`else
      cmp("t5_flush_hi", hi, 32'd5);
      cmp("t5_flush_lo", lo, 32'hFFFF_FFFF);
`endif
      drive(1'b1, OP_DIVU, 32'd9, 32'd4, 1'b0);
      c = cyc;
      model_div(c, 1'b0, 32'd9, 32'd4);
      wait_until(c + LAT + 2);
      cmp("t5_lo", lo, 32'd2);
      cmp("t5_hi", hi, 32'd1);

      // 6: back-to-back MTHI/MTLO, then watchdog with a stuck core
      drive(1'b1, OP_MTHI, 32'h0000_DEAD, 32'd0, 1'b0);
      set_hi(cyc + 1, 32'h0000_DEAD);
      drive(1'b1, OP_MTLO, 32'h0000_BEEF, 32'd0, 1'b0);
      set_lo(cyc + 1, 32'h0000_BEEF);
      drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
      cmp("t6_hi", hi, 32'h0000_DEAD);
      cmp("t6_lo", lo, 32'h0000_BEEF);

      hold_busy = 1'b1;
      drive(1'b1, OP_DIVU, 32'd50, 32'd5, 1'b0);
      c = cyc;
      exp_launch(c, c + 1 + MAX_WAIT, 1'b0, 32'd50, 32'd5);
      e_err[c+1+MAX_WAIT] = 1'b1;
      wait_until(c + MAX_WAIT + 3);
      hold_busy = 1'b0;
      cmp("t6_wd_hi", hi, 32'h0000_DEAD);
      cmp("t6_wd_lo", lo, 32'h0000_BEEF);

      // 7: reset in the middle of a division
      drive(1'b1, OP_DIVU, 32'd1000, 32'd3, 1'b0);
      c = cyc;
      exp_launch(c, c + 9, 1'b0, 32'd1000, 32'd3);
      wait_until(c + 9);
      @(posedge clock);
      #1;
      chk_en = 1'b0;
      reset  = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      cmp("t7_hi", hi, 32'd0);
      cmp("t7_lo", lo, 32'd0);
      cmp("t7_stall", {31'd0, stall}, 32'd0);
      set_hi(cyc, 32'd0);
      set_lo(cyc, 32'd0);
      chk_en = 1'b1;
      drive(1'b1, OP_MTLO, 32'h0000_0055, 32'd0, 1'b0);
      set_lo(cyc + 1, 32'h0000_0055);
      drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
      drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
      cmp("t7_mtlo", lo, 32'h0000_0055);

      @(negedge clock);
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
